// File: rtl/fp_div_d_sched.sv
// fp_div_d_sched: shares one combinational double-precision divider (fp_div_d)
// between two requesters with round-robin arbitration. The granted operands
// are registered and held at the divider for DIV_CYCLES cycles. The quotient
// is then returned on a registered response port, tagged with the requester ID.
//
// Optional feature macro: FP_DIV_SCHED_FLAGS_EN adds the rsp_flags output
// {invalid, divzero, overflow, underflow}, registered with rsp_result.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req0_valid/ready/a/b  requester 0 (a = dividend, b = divisor)
//   req1_valid/ready/a/b  requester 1
//   rsp_valid/ready       response handshake
//   rsp_result            64-bit quotient
//   rsp_id                index of the requester that issued the operation
//   busy                  high whenever the FSM is not in IDLE
//   rsp_flags             (FP_DIV_SCHED_FLAGS_EN only) exception flags
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. A producer holding valid keeps its payload stable until
// that edge. ready may depend combinationally on valid, but valid never
// depends on ready.

// Combinational IEEE-754 binary64 divider. Behaviour:
//   - the NaN result is canonical (0x7FF8000000000000);
//   - the mantissa quotient is truncated (round toward zero);
//   - results below the normal range flush to signed zero;
//   - subnormal operands are treated as zero.
module fp_div_d (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result
);
  logic               sa, sb, sq;
  logic [10:0]        ea, eb;
  logic [51:0]        fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [105:0]       num;
  logic [105:0]       den;
  logic [53:0]        quo;
  logic signed [12:0] exp_q;
  logic [51:0]        frac_q;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign sq = sa ^ sb;

  assign a_zero = (ea == 11'h000);
  assign b_zero = (eb == 11'h000);
  assign a_inf  = (ea == 11'h7FF) && (fa == 52'b0);
  assign b_inf  = (eb == 11'h7FF) && (fb == 52'b0);
  assign a_nan  = (ea == 11'h7FF) && (fa != 52'b0);
  assign b_nan  = (eb == 11'h7FF) && (fb != 52'b0);

  // Scaling the dividend by 2^53 puts ma/mb (in [0.5, 2)) into [2^52, 2^54).
  // So the quotient always fits in 54 bits, and bit 53 is the leading one
  // exactly when ma >= mb.
  assign num = {1'b1, fa, 53'b0};
  assign den = {53'b0, 1'b1, fb};
  assign quo = 54'(num / den);

  assign exp_q = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 13'sd1022
               + $signed({12'b0, quo[53]});
  assign frac_q = quo[53] ? quo[52:1] : quo[51:0];

  always_comb begin
    result = {sq, exp_q[10:0], frac_q};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      result = 64'h7FF8_0000_0000_0000;
    end else if (a_inf || b_zero) begin
      result = {sq, 11'h7FF, 52'b0};
    end else if (a_zero || b_inf) begin
      result = {sq, 63'b0};
    end else if (exp_q >= 13'sd2047) begin
      result = {sq, 11'h7FF, 52'b0};
    end else if (exp_q <= 13'sd0) begin
      result = {sq, 63'b0};
    end
  end
endmodule

module fp_div_d_sched #(
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_id,
  output logic        busy
`ifdef FP_DIV_SCHED_FLAGS_EN
  ,
  output logic [3:0]  rsp_flags
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(DIV_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [63:0] op_a, op_b;
  logic        tag;
  logic        last_grant;
  logic        grant0, grant1;
  logic [63:0] div_result;

  // Round robin: a lone requester wins. On a tie, the requester that was not
  // granted last wins. last_grant resets to 1, so requester 0 wins the first tie.
  assign grant1 = req1_valid && (!req0_valid || !last_grant);
  assign grant0 = req0_valid && !grant1;

  assign req0_ready = (state == IDLE) && grant0;
  assign req1_ready = (state == IDLE) && grant1;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  // The operand registers are the only inputs to the divider. They are
  // written only in IDLE, so they stay stable for the whole EXEC window.
  fp_div_d u_div (
    .a      (op_a),
    .b      (op_b),
    .result (div_result)
  );

`ifdef FP_DIV_SCHED_FLAGS_EN
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, q_inf, q_zero;
  logic [3:0] flags_d;

  assign a_nan  = (op_a[62:52] == 11'h7FF) && (op_a[51:0] != 52'b0);
  assign b_nan  = (op_b[62:52] == 11'h7FF) && (op_b[51:0] != 52'b0);
  assign a_inf  = (op_a[62:0] == {11'h7FF, 52'b0});
  assign b_inf  = (op_b[62:0] == {11'h7FF, 52'b0});
  assign a_zero = (op_a[62:0] == 63'b0);
  assign b_zero = (op_b[62:0] == 63'b0);
  assign q_inf  = (div_result[62:0] == {11'h7FF, 52'b0});
  assign q_zero = (div_result[62:0] == 63'b0);

  assign flags_d = {
    a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf),
    b_zero && !a_zero && !a_inf && !a_nan,
    q_inf && !a_inf && !b_zero,
    q_zero && !a_zero && !b_inf
  };
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      op_a       <= 64'b0;
      op_b       <= 64'b0;
      tag        <= 1'b0;
      last_grant <= 1'b1;
      rsp_result <= 64'b0;
      rsp_id     <= 1'b0;
`ifdef FP_DIV_SCHED_FLAGS_EN
      rsp_flags  <= 4'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_a       <= grant1 ? req1_a : req0_a;
            op_b       <= grant1 ? req1_b : req0_b;
            tag        <= grant1;
            last_grant <= grant1;
            cnt        <= CNT_LOAD;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // cnt counts the remaining hold cycles. The capture happens in the
          // last of the DIV_CYCLES cycles.
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_result <= div_result;
            rsp_id     <= tag;
`ifdef FP_DIV_SCHED_FLAGS_EN
            rsp_flags  <= flags_d;
`endif
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_d_sched.sv
// Testbench for fp_div_d_sched.
// - Directed vectors carry the quotient and flags given for them.
// - Random operations use a reference divider. It computes the exact quotient
//   with wide integer division and then normalises it.
// - A protocol model predicts ready, busy and rsp_valid every cycle.
// - A scoreboard monitor pops the expected {id, result, flags} on each
//   response handshake.
module tb_fp_div_d_sched;
  localparam int DIV_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_id;
  logic        busy;
`ifdef FP_DIV_SCHED_FLAGS_EN
  logic [3:0]  rsp_flags;
`endif

  fp_div_d_sched #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .busy       (busy)
`ifdef FP_DIV_SCHED_FLAGS_EN
   ,.rsp_flags  (rsp_flags)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [68:0] exp_q[$];   // {id, result[63:0], flags[3:0]}
  bit          rdy_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [67:0] ref_div(input logic [63:0] a, input logic [63:0] b);
    logic [10:0]  ea, eb;
    logic [51:0]  fa, fb;
    logic         s, an, bn, ai, bi, az, bz, inv, dz, ov, un;
    logic [127:0] num, q;
    logic [52:0]  mant;
    logic [63:0]  res;
    int           p, e;
    ea = a[62:52]; fa = a[51:0];
    eb = b[62:52]; fb = b[51:0];
    s  = a[63] ^ b[63];
    an = (ea == 11'h7FF) && (fa != 0);
    bn = (eb == 11'h7FF) && (fb != 0);
    ai = (ea == 11'h7FF) && (fa == 0);
    bi = (eb == 11'h7FF) && (fb == 0);
    az = (ea == 0) && (fa == 0);
    bz = (eb == 0) && (fb == 0);
    if (an || bn || (az && bz) || (ai && bi)) res = 64'h7FF8_0000_0000_0000;
    else if (ai || bz) res = {s, 11'h7FF, 52'b0};
    else if (az || bi) res = {s, 63'b0};
    else begin
      // value = 2^(ea-eb) * ma/mb, with ma/mb = q / 2^64 truncated
      num = {11'b0, 1'b1, fa, 64'b0};
      q   = num / {75'b0, 1'b1, fb};
      p   = 0;
      for (int i = 0; i < 128; i++) if (q[i]) p = i;
      mant = 53'(q >> (p - 52));
      e    = int'(ea) - int'(eb) + 1023 + (p - 64);
      if (e >= 2047)   res = {s, 11'h7FF, 52'b0};
      else if (e <= 0) res = {s, 63'b0};
      else             res = {s, 11'(e), mant[51:0]};
    end
    inv = an || bn || (az && bz) || (ai && bi);
    dz  = bz && !az && !ai && !an;
    ov  = (res[62:0] == {11'h7FF, 52'b0}) && !ai && !bz;
    un  = (res[62:0] == 63'b0) && !az && !bi;
    return {res, inv, dz, ov, un};
  endfunction

  function automatic logic [63:0] rnd_fp();
    logic [63:0] r;
    logic [10:0] e;
    int          k;
    r = {$urandom(), $urandom()};
    k = $urandom_range(0, 15);
    case (k)
      0:          return {r[63], 63'b0};
      1:          return {r[63], 11'h7FF, 52'b0};
      2:          return {r[63], 11'h7FF, r[51:1], 1'b1};
      3:          e = 11'($urandom_range(2030, 2046));
      4:          e = 11'($urandom_range(1, 16));
      5, 6, 7, 8: e = 11'($urandom_range(1000, 1046));
      default:    e = 11'($urandom_range(1, 2046));
    endcase
    return {r[63], e, r[51:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Call at a point between a rising edge and the following falling edge.
  task automatic issue(input bit r, input logic [63:0] a, input logic [63:0] b,
                       input logic [67:0] e);
    int  t;
    bit  rdy;
    t = 0;
    if (r) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    forever begin
      @(negedge clk);
      rdy = r ? req1_ready : req0_ready;
      if (rdy) break;
      t++;
      if (t > 2000) break;
    end
    if (!rdy) begin
      n_checks++;
      $display("FAIL accept_timeout: requester %0d got no ready, required ready within 2000 cycles", r);
    end else begin
      exp_q.push_back({r, e});
    end
    @(posedge clk); #1;
    if (r) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    if (rdy_mode) begin
      #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [68:0] mon_e;
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got id %0d result %h, required no response", rsp_id, rsp_result);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(mon_e[68]));
        chk("rsp_result", rsp_result, mon_e[67:4]);
`ifdef FP_DIV_SCHED_FLAGS_EN
        chk("rsp_flags", 64'(rsp_flags), 64'(mon_e[3:0]));
`endif
      end
    end
  end

  // ---------------- protocol / timing model ----------------
  // ph: 0 waiting for a request, 1 operation in flight, 2 response offered.
  int          ph = 0;
  int          left = 0;
  bit          m_last = 1'b1;
  bit          first = 1'b0;
  bit          exp_r0, exp_r1;
  logic [63:0] held_res;
  logic        held_id;

  always @(negedge clk) begin
    if (!rst_n) begin
      ph = 0; left = 0; m_last = 1'b1;
    end else begin
      exp_r0 = (ph == 0) && req0_valid && (!req1_valid || m_last);
      exp_r1 = (ph == 0) && req1_valid && (!req0_valid || !m_last);
      chk("req0_ready", 64'(req0_ready), 64'(exp_r0));
      chk("req1_ready", 64'(req1_ready), 64'(exp_r1));
      chk("busy", 64'(busy), 64'(ph != 0));
      chk("rsp_valid", 64'(rsp_valid), 64'(ph == 2));
      if (ph == 2) begin
        if (first) begin
          held_res = rsp_result; held_id = rsp_id; first = 1'b0;
        end else begin
          chk("rsp_hold_result", rsp_result, held_res);
          chk("rsp_hold_id", 64'(rsp_id), 64'(held_id));
        end
      end
      case (ph)
        0: if (exp_r0 || exp_r1) begin m_last = exp_r1; ph = 1; left = DIV_CYCLES; end
        1: begin left--; if (left == 0) begin ph = 2; first = 1'b1; end end
        default: if (rsp_ready) ph = 0;
      endcase
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  logic [63:0] ta, tb;
  int          wt;
  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_result", rsp_result, 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
`ifdef FP_DIV_SCHED_FLAGS_EN
    chk("reset_rsp_flags", 64'(rsp_flags), 64'd0);
`endif
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Tie out of reset: req0 first (basic 6/2), then req1 (1/0).
    fork
      issue(1'b0, 64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, {64'h4008_0000_0000_0000, 4'b0000});
      issue(1'b1, 64'h3FF0_0000_0000_0000, 64'h0, {64'h7FF0_0000_0000_0000, 4'b0100});
    join
    // Second tie after req1 was served: req0 (0/0) wins, then req1 (overflow).
    fork
      issue(1'b0, 64'h0, 64'h0, {64'h7FF8_0000_0000_0000, 4'b1000});
      issue(1'b1, 64'h7FE0_0000_0000_0000, 64'h3FE0_0000_0000_0000, {64'h7FF0_0000_0000_0000, 4'b0010});
    join
    issue(1'b0, 64'h0010_0000_0000_0000, 64'h4000_0000_0000_0000, {64'h0, 4'b0001});
    drain();

    // Backpressure: response held 10 cycles with req1 waiting.
    rsp_ready = 1'b0;
    ta = rnd_fp(); tb = rnd_fp();
    issue(1'b0, ta, tb, ref_div(ta, tb));
    ta = rnd_fp(); tb = rnd_fp();
    fork
      issue(1'b1, ta, tb, ref_div(ta, tb));
      begin
        wt = 0;
        while (!rsp_valid && wt < 50) begin @(negedge clk); wt++; end
        chk("bp_rsp_seen", 64'(rsp_valid), 64'd1);
        repeat (10) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    drain();

    // Randomized traffic from both requesters with random backpressure.
    rdy_mode = 1'b1;
    fork
      repeat (40) begin
        logic [63:0] a0, b0;
        repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
        a0 = rnd_fp(); b0 = rnd_fp();
        issue(1'b0, a0, b0, ref_div(a0, b0));
      end
      repeat (40) begin
        logic [63:0] a1, b1;
        repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
        a1 = rnd_fp(); b1 = rnd_fp();
        issue(1'b1, a1, b1, ref_div(a1, b1));
      end
    join
    rdy_mode = 1'b0;
    @(posedge clk); #2 rsp_ready = 1'b1;
    drain();

    // Reset during EXEC: outputs clear at once, no response afterwards.
    ta = rnd_fp(); tb = rnd_fp();
    issue(1'b0, ta, tb, ref_div(ta, tb));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_rsp_result", rsp_result, 64'd0);
    chk("midrst_rsp_id", 64'(rsp_id), 64'd0);
`ifdef FP_DIV_SCHED_FLAGS_EN
    chk("midrst_rsp_flags", 64'(rsp_flags), 64'd0);
`endif
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
